// File: rtl/controle_entrada_tempo.sv
// Debounced keypad entry of an MM:SS time as four BCD digits, shifted in from the right.
// Optional build macro VALIDA_SEGUNDOS_EN rejects keys that would put a value above 5 in seconds tens.
module controle_entrada_tempo #(
    parameter int DEBOUNCE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dado_valido,
    input  logic [3:0]  BCD,
    input  logic        iniciar,
    input  logic        cancelar,
    output logic        enablen,
    output logic [15:0] digitos,
    output logic [2:0]  num_digitos,
    output logic        entrada_ativa,
    output logic        pronto,
    output logic        erro,
    output logic [1:0]  estado
);

    // Encoder handshake: the encoder drives dado_valido/BCD only while enablen is low;
    // a key is taken once dado_valido and BCD stay unchanged for DEBOUNCE synchronized
    // cycles, and the next key needs DEBOUNCE synchronized cycles of dado_valido low first.

    localparam int CW = $clog2(DEBOUNCE + 2);
    localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESPERA_TECLA  = 2'd1,
        FILTRO        = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    logic       dv_s1, dv_s2;
    logic [3:0] bcd_s1, bcd_s2;

    estado_t       est_q, est_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    tecla_q, tecla_d;
    logic [15:0]   dig_d;
    logic [2:0]    num_d;
    logic          pronto_d;
    logic          aceita;
    logic          rejeita;

    assign estado  = est_q;
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dv_s1  <= 1'b0;
            dv_s2  <= 1'b0;
            bcd_s1 <= 4'd0;
            bcd_s2 <= 4'd0;
        end else begin
            dv_s1  <= dado_valido;
            dv_s2  <= dv_s1;
            bcd_s1 <= BCD;
            bcd_s2 <= bcd_s1;
        end
    end

`ifdef VALIDA_SEGUNDOS_EN
    // Shifting the current units digit into seconds tens must not exceed 5.
    assign rejeita = aceita && (num_digitos != 3'd0) && (digitos[3:0] > 4'd5);
`else
    assign rejeita = 1'b0;
`endif

    always_comb begin
        est_d    = est_q;
        cnt_d    = cnt_q;
        tecla_d  = tecla_q;
        dig_d    = digitos;
        num_d    = num_digitos;
        pronto_d = 1'b0;
        aceita   = 1'b0;

        if (cancelar) begin
            est_d = OCIOSO;
            cnt_d = '0;
            dig_d = 16'h0000;
            num_d = 3'd0;
        end else if (iniciar) begin
            est_d = ESPERA_TECLA;
            cnt_d = '0;
            dig_d = 16'h0000;
            num_d = 3'd0;
        end else begin
            case (est_q)
                OCIOSO: begin
                    cnt_d = '0;
                end
                ESPERA_TECLA: begin
                    if (dv_s2) begin
                        tecla_d = bcd_s2;
                        cnt_d   = CW'(1);
                        est_d   = FILTRO;
                    end
                end
                FILTRO: begin
                    if (dv_s2 && (bcd_s2 == tecla_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= LIMITE) begin
                            aceita = 1'b1;
                            cnt_d  = '0;
                            est_d  = ESPERA_SOLTAR;
                        end
                    end else begin
                        cnt_d = '0;
                        est_d = ESPERA_TECLA;
                    end
                end
                ESPERA_SOLTAR: begin
                    if (!dv_s2) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= LIMITE) begin
                            cnt_d = '0;
                            est_d = ESPERA_TECLA;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d = '0;
                    est_d = OCIOSO;
                end
            endcase

            if (aceita && !rejeita) begin
                dig_d = {digitos[11:0], tecla_q};
                num_d = num_digitos + 3'd1;
                if (num_d == 3'd4) begin
                    pronto_d = 1'b1;
                    est_d    = OCIOSO;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            est_q         <= OCIOSO;
            cnt_q         <= '0;
            tecla_q       <= 4'd0;
            digitos       <= 16'h0000;
            num_digitos   <= 3'd0;
            pronto        <= 1'b0;
            enablen       <= 1'b1;
            entrada_ativa <= 1'b0;
        end else begin
            est_q         <= est_d;
            cnt_q         <= cnt_d;
            tecla_q       <= tecla_d;
            digitos       <= dig_d;
            num_digitos   <= num_d;
            pronto        <= pronto_d;
            enablen       <= (est_d == OCIOSO);
            entrada_ativa <= (est_d != OCIOSO);
        end
    end

`ifdef VALIDA_SEGUNDOS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erro <= 1'b0;
        end else begin
            erro <= rejeita && !cancelar && !iniciar;
        end
    end
`else
    assign erro = 1'b0;
`endif

endmodule

// File: doc/controle_entrada_tempo.md
CONTROLE_ENTRADA_TEMPO -- requirements
Module: controle_entrada_tempo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable synchronized cycles required to accept a key.
REQ-003 Port clock  input  1  rising-edge system clock.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port dado_valido  input  1  key-present flag from the keypad priority encoder.
REQ-006 Port BCD  input  4  encoded key value from the keypad priority encoder.
REQ-007 Port iniciar  input  1  one-cycle pulse that starts a new time entry.
REQ-008 Port cancelar  input  1  one-cycle pulse that aborts entry and clears digits.
REQ-009 Port enablen  output  1  active-low enable driven to the encoder; 0 only while entry is active.
REQ-010 Port digitos  output  16  entered time as MM:SS BCD; [15:12] minute tens, [3:0] second units.
REQ-011 Port num_digitos  output  3  count of accepted digits, 0..4.
REQ-012 Port entrada_ativa  output  1  high while in any entry state.
REQ-013 Port pronto  output  1  one-cycle pulse when the fourth digit is accepted.
REQ-014 Port erro  output  1  one-cycle pulse on a rejected key (only with VALIDA_SEGUNDOS_EN).

Function
REQ-015 dado_valido and BCD SHALL pass through a two-flop synchronizer before any use.
REQ-016 FSM states SHALL be OCIOSO, ESPERA_TECLA, FILTRO and ESPERA_SOLTAR.
- OCIOSO: on iniciar, clear digitos and num_digitos, then go to ESPERA_TECLA.
- ESPERA_TECLA: when synchronized dado_valido=1, capture synchronized BCD, load the debounce counter with 1 and go to FILTRO.
- FILTRO: increment while dado_valido=1 and BCD equals the captured value. On a drop or value change, return to ESPERA_TECLA without accepting.
- FILTRO: when the counter reaches DEBOUNCE, accept the key that same cycle and go to ESPERA_SOLTAR.
- ESPERA_SOLTAR: wait for DEBOUNCE consecutive cycles of dado_valido=0, then go to ESPERA_TECLA.
REQ-017 On accept, digitos SHALL shift left by 4 bits, the new digit SHALL enter [3:0], and num_digitos SHALL increment.
REQ-018 When the accept makes num_digitos equal 4:
- pronto SHALL pulse that cycle.
- The FSM SHALL go to OCIOSO; digitos and num_digitos SHALL hold until the next iniciar or reset.
REQ-019 A held key SHALL yield exactly one digit, regardless of hold duration.
REQ-020 cancelar SHALL take priority over every other event in every state: next cycle state is OCIOSO and digitos=0, num_digitos=0; no pronto pulse.
REQ-021 iniciar received outside OCIOSO SHALL restart entry: clear digitos and num_digitos, then go to ESPERA_TECLA.
REQ-022 iniciar and cancelar asserted in the same cycle SHALL resolve as cancelar.
REQ-023 enablen SHALL be 1 in OCIOSO and 0 in all other states; entrada_ativa SHALL equal ~enablen.
REQ-024 In OCIOSO, BCD input values SHALL be ignored.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Reset SHALL force the state to OCIOSO and set enablen=1, entrada_ativa=0, digitos=16'h0000, num_digitos=0, pronto=0, erro=0, and clear all counters and synchronizers, asynchronously.
REQ-027 Reset asserted mid-entry SHALL discard partial digits; after reset release, the block SHALL accept no key until a new iniciar.

Configuration
REQ-028 With macro VALIDA_SEGUNDOS_EN defined, an accepted key whose shift would place a value >5 into seconds tens ([7:4]) SHALL be rejected:
- Applies when the current [3:0] > 5 and num_digitos >= 1.
- digitos and num_digitos SHALL be unchanged.
- erro SHALL pulse for one cycle.
- The FSM SHALL still go to ESPERA_SOLTAR.
REQ-029 Without VALIDA_SEGUNDOS_EN, every accepted key SHALL shift in, and erro SHALL be tied to 0.

Verification
REQ-030 Reset, iniciar, then keys 1,2,3,0, each held 10 cycles with a 10-cycle release (DEBOUNCE=4) -> digitos=16'h1230, num_digitos=4, one pronto pulse, enablen returns to 1.
REQ-031 A key 7 glitch held 2 cycles, then key 7 held 20 cycles -> exactly one digit 7, digitos=16'h0007.
REQ-032 Keys 4,5 accepted, then cancelar -> next cycle digitos=0, num_digitos=0, enablen=1; further keys are ignored.
REQ-033 Reset pulse during FILTRO for key 9 -> all outputs at reset values, no digit stored.
REQ-034 With VALIDA_SEGUNDOS_EN: keys 8 then 3 -> the 3 is rejected, erro pulses once, digitos=16'h0008. Without the macro, the same stimulus -> digitos=16'h0083.
REQ-035 Key value changes from 2 to 6 inside the debounce window -> the counter restarts, and only 6 is accepted after DEBOUNCE stable cycles.
